uart_rx: RTL and testbench

Serial receiver that consumes the one-cycle 16x oversample enable produced by the team's baud generator and recovers 8N1 frames from the `rx` pin. It synchronizes the asynchronous line, validates the start bit, samples each bit at its centre, and presents each byte with a one-cycle `valid` strobe. It sits between the board UART pin and the command parser; framing errors are flagged and never delivered as data.

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 serial receiver driven by a 16x oversample tick; centre
//                sampling, start-glitch rejection and framing-error detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_TW = $clog2(OVERSAMPLE);
    localparam int c_BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_TW-1:0] c_T_HALF = c_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(OVERSAMPLE - 1);
    localparam logic [c_TW-1:0] c_T_ONE  = c_TW'(1);
    localparam logic [c_BW-1:0] c_B_LAST = c_BW'(DATA_BITS - 1);
    localparam logic [c_BW-1:0] c_B_ONE  = c_BW'(1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;
    logic [2:0]           r_state;
    logic [c_TW-1:0]      r_tcnt;
    logic [c_BW-1:0]      r_bcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;

    // Line is idle-high, so the synchronizer resets high to avoid a false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if (tick) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (!w_rx_s) begin
                            r_state <= c_ST_START;
                            r_tcnt  <= '0;
                        end
                    end
                    c_ST_START: begin
                        if (r_tcnt == c_T_HALF) begin
                            if (!w_rx_s) begin
                                r_state <= c_ST_DATA;
                                r_tcnt  <= '0;
                                r_bcnt  <= '0;
                            end else begin
                                r_state <= c_ST_IDLE;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + c_T_ONE;
                        end
                    end
                    c_ST_DATA: begin
                        if (r_tcnt == c_T_LAST) begin
                            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            r_tcnt  <= '0;
                            if (r_bcnt == c_B_LAST) begin
                                r_state <= c_ST_STOP;
                            end else begin
                                r_bcnt <= r_bcnt + c_B_ONE;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + c_T_ONE;
                        end
                    end
                    c_ST_STOP: begin
                        if (r_tcnt == c_T_LAST) begin
                            r_tcnt <= '0;
                            if (w_rx_s) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                                r_state <= c_ST_IDLE;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= c_ST_BREAK;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + c_T_ONE;
                        end
                    end
                    // Wait for the line to recover so a held-low line cannot retrigger.
                    c_ST_BREAK: begin
                        if (w_rx_s) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx against a tick-offset model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_OS = 16;
    localparam int c_DB = 8;

    logic            clk;
    logic            rst;
    logic            tick;
    logic            rx;
    logic [c_DB-1:0] data;
    logic            valid;
    logic            frame_err;
    logic            busy;

    int checks;
    int errors;
    int n_valid;
    int n_ferr;
    int busy_cyc;
    int cyc;
    bit tick_en;
    logic [7:0] got_q[$];

    // model state
    logic       m_s1, m_s2, m_s;
    int         m_mode;
    int         m_rel;
    logic [7:0] m_byte;
    logic       exp_valid, exp_ferr, exp_busy;
    logic [7:0] exp_data;

    uart_rx #(.OVERSAMPLE(c_OS), .DATA_BITS(c_DB)) dut (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx),
        .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        cyc  = 0;
        forever begin
            @(negedge clk);
            cyc  = cyc + 1;
            tick = tick_en && (cyc % 4 == 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            if (errors < 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame decoded purely from tick offsets relative to the detection tick.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_mode = 0; m_rel = 0; m_byte = '0;
            exp_valid = 1'b0; exp_ferr = 1'b0; exp_busy = 1'b0; exp_data = '0;
        end else begin
            m_s = m_s2;
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            if (tick) begin
                if (m_mode == 0) begin
                    if (!m_s) begin m_mode = 1; m_rel = 0; m_byte = '0; end
                end else if (m_mode == 1) begin
                    m_rel = m_rel + 1;
                    if (m_rel == c_OS/2 && m_s) begin
                        m_mode = 0;
                    end else if (m_rel >= c_OS/2 + c_OS && m_rel <= c_OS/2 + c_OS*c_DB
                                 && (m_rel - c_OS/2) % c_OS == 0) begin
                        m_byte[(m_rel - c_OS/2 - c_OS) / c_OS] = m_s;
                    end else if (m_rel == c_OS/2 + c_OS*(c_DB+1)) begin
                        if (m_s) begin exp_valid = 1'b1; exp_data = m_byte; m_mode = 0; end
                        else begin exp_ferr = 1'b1; m_mode = 2; end
                    end
                end else begin
                    if (m_s) m_mode = 0;
                end
            end
            exp_busy = (m_mode != 0);
            m_s2 = m_s1;
            m_s1 = rx;
        end
    end

    always @(negedge clk) begin
        chk("valid", int'(valid), int'(exp_valid));
        chk("frame_err", int'(frame_err), int'(exp_ferr));
        chk("data", int'(data), int'(exp_data));
        chk("busy", int'(busy), int'(exp_busy));
        chk("valid_and_ferr", int'(valid & frame_err), 0);
        if (valid) begin n_valid = n_valid + 1; got_q.push_back(data); end
        if (frame_err) n_ferr = n_ferr + 1;
        if (busy) busy_cyc = busy_cyc + 1;
    end

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int budget;
            budget = 0;
            @(posedge clk);
            while (!tick) begin
                budget = budget + 1;
                if (budget > 2000) begin
                    $display("FAIL tick_wait: got no tick expected tick within 2000 clk");
                    errors = errors + 1;
                    $fatal(1, "tick timeout");
                end
                @(posedge clk);
            end
        end
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv);
        drive_bit(1'b0, c_OS);
        for (int i = 0; i < c_DB; i++) drive_bit(b[i], c_OS);
        drive_bit(stopv, c_OS);
        rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, nf;
        logic [7:0] b;
        logic sb;
        checks = 0; errors = 0; n_valid = 0; n_ferr = 0; busy_cyc = 0;
        tick_en = 1'b1;
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(5);

        // single frame
        send_frame(8'hA5, 1'b1);
        wait_ticks(4);
        chk("single_data", int'(data), 32'hA5);
        chk("single_model", int'(exp_data), 32'hA5);
        chk("single_nvalid", n_valid, 1);
        chk("single_nferr", n_ferr, 0);
        chk("single_busy", int'(busy), 0);

        // back-to-back
        got_q.delete();
        send_frame(8'h00, 1'b1);
        drive_bit(1'b1, c_OS);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        wait_ticks(10);
        chk("b2b_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("b2b_0", int'(got_q[0]), 32'h00);
            chk("b2b_1", int'(got_q[1]), 32'hFF);
            chk("b2b_2", int'(got_q[2]), 32'h55);
        end

        // start glitch
        wait_ticks(10);
        nv = n_valid; nf = n_ferr; busy_cyc = 0;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 30);
        chk("glitch_busy_clk", busy_cyc, 32);
        chk("glitch_nvalid", n_valid, nv);
        chk("glitch_nferr", n_ferr, nf);

        // framing error followed by held-low line
        nv = n_valid; nf = n_ferr;
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 40);
        chk("ferr_busy_low", int'(busy), 1);
        drive_bit(1'b1, 20);
        chk("ferr_nferr", n_ferr, nf + 1);
        chk("ferr_nvalid", n_valid, nv);
        chk("ferr_data", int'(data), 32'h55);
        chk("ferr_busy_after", int'(busy), 0);

        // reset mid-frame during bit 3 of 0x81
        drive_bit(1'b0, c_OS);
        drive_bit(1'b1, c_OS);
        drive_bit(1'b0, c_OS);
        drive_bit(1'b0, c_OS);
        drive_bit(1'b0, 8);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_data", int'(data), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_ferr", int'(frame_err), 0);
        chk("arst_busy", int'(busy), 0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(20);
        send_frame(8'h81, 1'b1);
        wait_ticks(4);
        chk("arst_frame", int'(data), 32'h81);

        // tick starvation in the middle of bit 2 of 0xC3
        b = 8'hC3;
        drive_bit(1'b0, c_OS);
        drive_bit(b[0], c_OS);
        drive_bit(b[1], c_OS);
        drive_bit(b[2], 5);
        tick_en = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1 rx = 1'($urandom_range(0, 1));
        end
        rx = b[2];
        repeat (6) @(posedge clk);
        #1 tick_en = 1'b1;
        wait_ticks(11);
        for (int i = 3; i < c_DB; i++) drive_bit(b[i], c_OS);
        drive_bit(1'b1, c_OS);
        wait_ticks(4);
        chk("starve_data", int'(data), 32'hC3);

        // randomized frames, gaps and bad stop bits
        for (int f = 0; f < 14; f++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            send_frame(b, sb);
            drive_bit(1'b1, $urandom_range(0, 24));
        end
        wait_ticks(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
